// File: rtl/countdown_timer_ctrl_if.sv
// rtl/countdown_timer_ctrl_if.sv - control/status bundle between button logic, timer and display driver
interface countdown_timer_ctrl_if;
    logic       start;
    logic       pause;
    logic       clear;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic       running;
    logic       paused;
    logic       done;
    logic       alarm;

    modport master (
        output start, pause, clear, load_min, load_sec,
        input  cur_min, cur_sec, running, paused, done, alarm
    );

    modport slave (
        input  start, pause, clear, load_min, load_sec,
        output cur_min, cur_sec, running, paused, done, alarm
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - BCD mm:ss countdown with 1 s prescaler; optional ALARM_BLINK_EN
module countdown_timer_ctrl #(
    parameter logic [31:0] TICK_DIV   = 32'd50_000_000,
    parameter int unsigned ALARM_SECS = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    countdown_timer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state;
    logic [31:0] prescaler;
    logic [7:0]  cur_min_q;
    logic [7:0]  cur_sec_q;
    logic        running_q;
    logic        paused_q;
    logic        done_q;
    logic        alarm_q;

    logic [7:0]  ld_min;
    logic [7:0]  ld_sec;
    logic        load_nz;
    logic        tick_hit;
    logic [31:0] pre_next;
    logic        expire;
    logic        pause_req;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
        return (d > max_d) ? max_d : d;
    endfunction

    // Two-digit BCD decrement; caller handles the 00 case (never reaches here at 00).
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        else
            return {v[7:4] - 4'd1, 4'd9};
    endfunction

    assign ld_min    = {clamp_digit(bus.load_min[7:4], 4'd9), clamp_digit(bus.load_min[3:0], 4'd9)};
    assign ld_sec    = {clamp_digit(bus.load_sec[7:4], 4'd5), clamp_digit(bus.load_sec[3:0], 4'd9)};
    assign load_nz   = (ld_min != 8'h00) || (ld_sec != 8'h00);
    assign tick_hit  = (prescaler == TICK_DIV - 32'd1);
    assign pre_next  = tick_hit ? 32'd0 : prescaler + 32'd1;
    assign expire    = tick_hit && (cur_min_q == 8'h00) && (cur_sec_q == 8'h01);
    // start outranks pause when both arrive together
    assign pause_req = bus.pause && !bus.start;

`ifdef ALARM_BLINK_EN
    logic [31:0] alarm_ticks;
    logic [31:0] alarm_ticks_next;
    assign alarm_ticks_next = (tick_hit && (alarm_ticks < 32'(ALARM_SECS))) ? alarm_ticks + 32'd1
                                                                           : alarm_ticks;
`endif

    // Main sequencer: state, prescaler, BCD count and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prescaler <= 32'd0;
            cur_min_q <= 8'h00;
            cur_sec_q <= 8'h00;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
`ifdef ALARM_BLINK_EN
            alarm_ticks <= 32'd0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                state     <= IDLE;
                prescaler <= 32'd0;
                alarm_q   <= 1'b0;
                running_q <= 1'b0;
                paused_q  <= 1'b0;
`ifdef ALARM_BLINK_EN
                alarm_ticks <= 32'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        cur_min_q <= ld_min;
                        cur_sec_q <= ld_sec;
                        if (bus.start && load_nz) begin
                            state     <= RUN;
                            prescaler <= 32'd0;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        prescaler <= pre_next;
                        if (expire) begin
                            cur_sec_q <= 8'h00;
                            state     <= DONE;
                            done_q    <= 1'b1;
                            alarm_q   <= 1'b1;
                            running_q <= 1'b0;
`ifdef ALARM_BLINK_EN
                            alarm_ticks <= 32'd0;
`endif
                        end else begin
                            if (tick_hit) begin
                                if (cur_sec_q == 8'h00) begin
                                    cur_sec_q <= 8'h59;
                                    cur_min_q <= bcd_dec(cur_min_q);
                                end else begin
                                    cur_sec_q <= bcd_dec(cur_sec_q);
                                end
                            end
                            if (pause_req) begin
                                state     <= PAUSE;
                                running_q <= 1'b0;
                                paused_q  <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (bus.start) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                            paused_q  <= 1'b0;
                        end
                    end
                    DONE: begin
                        if (bus.start && load_nz) begin
                            cur_min_q <= ld_min;
                            cur_sec_q <= ld_sec;
                            prescaler <= 32'd0;
                            state     <= RUN;
                            running_q <= 1'b1;
                            alarm_q   <= 1'b0;
                        end else begin
`ifdef ALARM_BLINK_EN
                            prescaler   <= pre_next;
                            alarm_ticks <= alarm_ticks_next;
                            alarm_q     <= (alarm_ticks_next < 32'(ALARM_SECS)) &&
                                           (pre_next < (TICK_DIV >> 1));
`else
                            prescaler <= 32'd0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cur_min = cur_min_q;
    assign bus.cur_sec = cur_sec_q;
    assign bus.running = running_q;
    assign bus.paused  = paused_q;
    assign bus.done    = done_q;
    assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - vector table plus scoreboard bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    countdown_timer_ctrl_if bus();

    countdown_timer_ctrl #(
        .TICK_DIV   (32'd4),
        .ALARM_SECS (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       start, pause, clear;
        logic [7:0] lmin, lsec;
        logic [7:0] emin, esec;
        logic       erun, epau, edone, ealarm;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] emin, esec;
        logic       erun, epau, edone, ealarm;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic st, input logic pa, input logic cl,
                       input logic [7:0] lmin, input logic [7:0] lsec,
                       input logic [7:0] emin, input logic [7:0] esec,
                       input logic run, input logic pau, input logic dn, input logic al,
                       input string name);
        vec_t v;
        v.start = st; v.pause = pa; v.clear = cl;
        v.lmin = lmin; v.lsec = lsec;
        v.emin = emin; v.esec = esec;
        v.erun = run; v.epau = pau; v.edone = dn; v.ealarm = al;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check_out(input exp_t e);
        checks++;
        if ({bus.cur_min, bus.cur_sec, bus.running, bus.paused, bus.done, bus.alarm} !==
            {e.emin, e.esec, e.erun, e.epau, e.edone, e.ealarm}) begin
            errors++;
            $display("FAIL %s: got min=%h sec=%h run=%b pau=%b done=%b alarm=%b want min=%h sec=%h run=%b pau=%b done=%b alarm=%b",
                     e.name, bus.cur_min, bus.cur_sec, bus.running, bus.paused, bus.done, bus.alarm,
                     e.emin, e.esec, e.erun, e.epau, e.edone, e.ealarm);
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, push expectation, pop and compare after the edge.
    task automatic cycle(input vec_t v);
        exp_t e;
        bus.start = v.start; bus.pause = v.pause; bus.clear = v.clear;
        bus.load_min = v.lmin; bus.load_sec = v.lsec;
        e.emin = v.emin; e.esec = v.esec; e.erun = v.erun; e.epau = v.epau;
        e.edone = v.edone; e.ealarm = v.ealarm; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue want one entry");
        end else begin
            check_out(sb.pop_front());
        end
    endtask

    initial begin
        exp_t z;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        bus.load_min = 8'h00; bus.load_sec = 8'h00;

        // Test 1: 00:03 countdown, expiry at 12 cycles
        add(0,0,0, 8'h00,8'h03, 8'h00,8'h03, 0,0,0,0, "t1_preview");
        add(1,0,0, 8'h00,8'h03, 8'h00,8'h03, 1,0,0,0, "t1_start");
        for (int k = 1; k <= 13; k++)
            add(0,0,0, 8'h00,8'h03, 8'h00, 8'(3 - k/4), k < 12, 0, k == 12, k >= 12, "t1_count");
        // Test 2: reload from DONE, minute borrow
        add(1,0,0, 8'h01,8'h00, 8'h01,8'h00, 1,0,0,0, "t2_reload");
        for (int k = 1; k <= 3; k++)
            add(0,0,0, 8'h01,8'h00, 8'h01,8'h00, 1,0,0,0, "t2_hold");
        add(0,0,0, 8'h01,8'h00, 8'h00,8'h59, 1,0,0,0, "t2_borrow");
        add(0,0,1, 8'h01,8'h00, 8'h00,8'h59, 0,0,0,0, "t2_clear");
        // Test 3: pause at prescaler=2, resume 2 cycles to next decrement
        add(0,0,0, 8'h00,8'h10, 8'h00,8'h10, 0,0,0,0, "t3_preview");
        add(1,0,0, 8'h00,8'h10, 8'h00,8'h10, 1,0,0,0, "t3_start");
        for (int k = 1; k <= 5; k++)
            add(0,0,0, 8'h00,8'h10, 8'h00, (k < 4) ? 8'h10 : 8'h09, 1,0,0,0, "t3_run");
        add(0,1,0, 8'h00,8'h10, 8'h00,8'h09, 0,1,0,0, "t3_pause");
        for (int j = 0; j < 20; j++)
            add(0, j == 10, 0, 8'h00,8'h10, 8'h00,8'h09, 0,1,0,0, "t3_frozen");
        for (int k = 0; k <= 14; k++)
            add(k == 0, 0, 0, 8'h00,8'h10, 8'h00, 8'(9 - (k + 2)/4), 1,0,0,0, "t3_resume");
        // Test 4: start+clear together at 00:05
        add(1,0,1, 8'h00,8'h10, 8'h00,8'h05, 0,0,0,0, "t4_start_clear");
        add(0,0,0, 8'h00,8'h10, 8'h00,8'h10, 0,0,0,0, "t4_preview");
        // Test 5: clamping of invalid digits
        add(0,0,0, 8'hA3,8'h7A, 8'h93,8'h59, 0,0,0,0, "t5_clamp_preview");
        add(1,0,0, 8'hA3,8'h7A, 8'h93,8'h59, 1,0,0,0, "t5_clamp_load");
        add(0,0,1, 8'hA3,8'h7A, 8'h93,8'h59, 0,0,0,0, "t5_clear");
        // Test 6: zero load is ignored
        add(0,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0,0, "t6_zero_preview");
        add(1,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0,0, "t6_zero_start");
        add(0,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0,0, "t6_stay_idle");
        add(0,1,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0,0, "t6_pause_idle");
        // Test 7: pause coinciding with a tick, then resume to expiry
        add(0,0,0, 8'h00,8'h02, 8'h00,8'h02, 0,0,0,0, "t7_preview");
        add(1,0,0, 8'h00,8'h02, 8'h00,8'h02, 1,0,0,0, "t7_start");
        for (int k = 1; k <= 3; k++)
            add(0,0,0, 8'h00,8'h02, 8'h00,8'h02, 1,0,0,0, "t7_run");
        add(0,1,0, 8'h00,8'h02, 8'h00,8'h01, 0,1,0,0, "t7_tick_pause");
        add(1,0,0, 8'h00,8'h02, 8'h00,8'h01, 1,0,0,0, "t7_resume");
        for (int k = 1; k <= 3; k++)
            add(0,0,0, 8'h00,8'h02, 8'h00,8'h01, 1,0,0,0, "t7_run2");
        add(0,0,0, 8'h00,8'h02, 8'h00,8'h00, 0,0,1,1, "t7_expire");
        add(0,0,1, 8'h00,8'h02, 8'h00,8'h00, 0,0,0,0, "t7_clear");
        // Test 8 lead-in: run 00:05 before async reset
        add(1,0,0, 8'h00,8'h05, 8'h00,8'h05, 1,0,0,0, "t8_start");
        add(0,0,0, 8'h00,8'h05, 8'h00,8'h05, 1,0,0,0, "t8_run");
        add(0,0,0, 8'h00,8'h05, 8'h00,8'h05, 1,0,0,0, "t8_run");

        z.emin = 8'h00; z.esec = 8'h00; z.erun = 1'b0; z.epau = 1'b0;
        z.edone = 1'b0; z.ealarm = 1'b0;

        #3;
        z.name = "reset_state";
        check_out(z);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) cycle(vecs[i]);

        // Asynchronous reset mid-RUN, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        z.name = "async_reset";
        check_out(z);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            vec_t v;
            v.start = 0; v.pause = 0; v.clear = 0;
            v.lmin = 8'h00; v.lsec = 8'h05;
            v.emin = 8'h00; v.esec = 8'h05;
            v.erun = 0; v.epau = 0; v.edone = 0; v.ealarm = 0;
            v.name = "post_reset_idle";
            cycle(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
